// File: rtl/dsp_main.sv
// Audio DSP core: internal sample-rate divider and one-pole low-pass IIR.
// Captures one PCM sample per tick and holds the filtered result for a sample period.
`timescale 1ns/1ps
module dsp_main #(
   parameter int DATA_W      = 16,
   parameter int CLK_DIV     = 64,
   parameter int ALPHA_SHIFT = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] sample_in,
   output logic signed [DATA_W-1:0] sample_out
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int AW = DATA_W + ALPHA_SHIFT;

   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_ZERO = '0;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic signed [AW-1:0] Y_MAX = AW'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [AW-1:0] Y_MIN = AW'(-(2 ** (DATA_W - 1)));

   logic        [CW-1:0]     cnt_q, cnt_d;
   logic signed [DATA_W-1:0] x_q;
   logic signed [AW-1:0]     acc_q, acc_d;
   logic signed [DATA_W-1:0] out_q;

   logic                     tick;
   logic                     upd_acc;
   logic                     upd_out;
   logic signed [AW-1:0]     x_ext;
   logic signed [AW-1:0]     y_full;
   logic signed [DATA_W-1:0] y_sat;

   assign tick    = (cnt_q == CNT_LAST);
   assign upd_acc = (cnt_q == CNT_ZERO);
   assign upd_out = (cnt_q == CNT_ONE);

   assign cnt_d  = tick ? CNT_ZERO : cnt_q + CNT_ONE;
   assign x_ext  = AW'(x_q);
   assign acc_d  = acc_q + x_ext - (acc_q >>> ALPHA_SHIFT);
   assign y_full = acc_q >>> ALPHA_SHIFT;

   // Clamp cannot trigger with this acc width; it guards against wrap only.
   always_comb begin
      y_sat = y_full[DATA_W-1:0];
      if (y_full > Y_MAX) begin
         y_sat = Y_MAX[DATA_W-1:0];
      end else if (y_full < Y_MIN) begin
         y_sat = Y_MIN[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         x_q   <= '0;
         acc_q <= '0;
         out_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (tick) begin
            x_q <= sample_in;
         end
         if (upd_acc) begin
            acc_q <= acc_d;
         end
         if (upd_out) begin
            out_q <= y_sat;
         end
      end
   end

   assign sample_out = out_q;

endmodule

// File: tb/tb_dsp_main.sv
// Bench for dsp_main: filtered build (alpha 1/8) and bypass build side by side.
// Expected outputs come from a per-sample-period arithmetic model of the filter.
`timescale 1ns/1ps
module tb_dsp_main;
   logic               clk;
   logic               rst_n;
   logic signed [15:0] sin_a;
   logic signed [15:0] sin_b;
   logic signed [15:0] out_a;
   logic signed [15:0] out_b;

   int n_chk;
   int n_fail;

   int acc_a, acc_b;
   int prev_a, prev_b;

   dsp_main #(.DATA_W(16), .CLK_DIV(64), .ALPHA_SHIFT(3)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_in  (sin_a),
      .sample_out (out_a)
   );

   dsp_main #(.DATA_W(16), .CLK_DIV(64), .ALPHA_SHIFT(0)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_in  (sin_b),
      .sample_out (out_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int fdiv(input int a, input int sh);
      int d;
      d = 1 << sh;
      if (a >= 0) return a / d;
      return -((-a + d - 1) / d);
   endfunction

   function automatic int clamp16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      acc_a  = 0;
      acc_b  = 0;
      prev_a = 0;
      prev_b = 0;
   endtask

   // Entered just after the 2nd edge of a period; leaves at the same phase.
   task automatic period(input int xa, input int xb);
      int ya, yb;
      sin_a = 16'(xa);
      sin_b = 16'(xb);
      acc_a = acc_a + xa - fdiv(acc_a, 3);
      acc_b = acc_b + xb - fdiv(acc_b, 0);
      ya = clamp16(fdiv(acc_a, 3));
      yb = clamp16(fdiv(acc_b, 0));
      step(63);
      chk("hold_a", out_a, prev_a);
      chk("hold_b", out_b, prev_b);
      step(1);
      chk("out_a", out_a, ya);
      chk("out_b", out_b, yb);
      prev_a = ya;
      prev_b = yb;
   endtask

   function automatic int rnd16();
      return int'($urandom_range(65535)) - 32768;
   endfunction

   task automatic mid_reset();
      step(20);
      rst_n = 1'b0;
      step(1);
      chk("mrst_a", out_a, 0);
      chk("mrst_b", out_b, 0);
      rst_n = 1'b1;
      model_reset();
      step(2);
      chk("mrel_a", out_a, 0);
   endtask

   task automatic run_monotonic(input int x, input int n, input bit up);
      int last;
      last = out_a;
      for (int i = 0; i < n; i++) begin
         period(x, rnd16());
         chk("mono", (up ? (out_a >= last) : (out_a <= last)) ? 1 : 0, 1);
         last = out_a;
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      model_reset();
      rst_n = 1'b0;
      sin_a = 16'h1234;
      sin_b = 16'h1234;
      step(10);
      chk("rst_a", out_a, 0);
      chk("rst_b", out_b, 0);
      rst_n = 1'b1;
      step(2);
      chk("rel_a", out_a, 0);

      period(8000, 32767);
      chk("step1", out_a, 1000);
      period(8000, -32768);
      chk("step2", out_a, 1875);
      period(8000, 0);
      chk("step3", out_a, 2640);
      run_monotonic(8000, 97, 1'b1);
      chk("step_fin", out_a, 8000);

      mid_reset();
      period(8000, rnd16());
      chk("restart", out_a, 1000);

      run_monotonic(-32768, 150, 1'b0);
      chk("neg_fin", out_a, -32768);
      run_monotonic(32767, 200, 1'b1);
      chk("pos_fin", out_a, 32767);

      mid_reset();
      period(0, rnd16());
      period(0, rnd16());
      period(16000, rnd16());
      chk("imp0", out_a, 2000);
      period(0, rnd16());
      chk("imp1", out_a, 1750);
      period(0, rnd16());
      chk("imp2", out_a, 1531);
      run_monotonic(0, 100, 1'b0);
      chk("imp_fin", out_a, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dsp_main.md
Name: dsp_main

Overview:
- Top-level audio DSP core that sits between the audio sample source and the audio sink.
- Runs from a single system clock at CLK_DIV times the audio sample rate (64 x 44.1 kHz = 2.8224 MHz). It generates its own sample-rate tick internally.
- Captures one signed 16-bit PCM sample per tick and applies a one-pole low-pass IIR filter.
- Presents the filtered sample, held stable for a full sample period.

Parameters:
- DATA_W, 16, PCM sample width; two's-complement signed.
- CLK_DIV, 64, system clocks per audio sample; must be >= 4.
- ALPHA_SHIFT, 3, filter coefficient alpha = 2^-ALPHA_SHIFT; range 0..8.

Ports:
- clk  input  1  system clock, rising-edge active; sole clock.
- rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
- sample_in  input  DATA_W  signed PCM input; upstream holds it stable for CLK_DIV clocks, changing at most once per sample period.
- sample_out  output  DATA_W  signed filtered PCM output; registered.

Behaviour:
- Reset (rst_n=0 at a rising edge) clears the following registers to 0: divider counter cnt, input register x_reg, accumulator acc, sample_out. Reset has priority over all other activity.
- Reset asserted mid-sample discards any in-flight sample. After release, timing restarts from cnt=0.
- Divider: cnt counts 0..CLK_DIV-1 and wraps to 0. tick = (cnt == CLK_DIV-1).
- Pipeline, one register stage per edge:
  - Stage 1 (edge with tick=1): x_reg <= sample_in.
  - Stage 2 (edge with cnt==0): acc <= acc + sext(x_reg) - (acc >>> ALPHA_SHIFT).
  - Stage 3 (edge with cnt==1): sample_out <= acc >>> ALPHA_SHIFT, truncated to DATA_W.
- acc width is DATA_W+ALPHA_SHIFT bits, signed. `>>>` is an arithmetic shift, i.e. floor toward minus infinity.
- Equivalent filter: y[n] = floor(acc[n] / 2^ALPHA_SHIFT), acc[n] = acc[n-1] + x[n] - y[n-1]. Steady-state gain is exactly 1 (acc = x * 2^ALPHA_SHIFT).
- Overflow: none is possible with this acc width. Nevertheless, sample_out must saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] if the truncated value would wrap; this is a defensive clamp.
- ALPHA_SHIFT=0 gives bypass: y[n] = x[n], i.e. sample_out equals the captured sample after latency.
- Latency: sample_out reflects the sample captured at edge k on edge k+2. It then holds constant for CLK_DIV clocks.
- After reset release, the first capture is on the CLK_DIV-th rising edge (edge 64). The first possible output update is on edge 66.
- Capture-phase alignment with the source is arbitrary. Because the input is stable for CLK_DIV clocks, any phase yields each sample exactly once.
- sample_out changes only on edges where cnt==1 (pre-edge value). It is glitch-free, being a register output.

Test Plan:
- Reset: hold rst_n=0 for 10 clocks with sample_in=16'h1234 -> sample_out=0. After release, sample_out stays 0 through edge 65; cnt wraps at edge 64.
- Step response (ALPHA_SHIFT=3), sample_in=8000 constant from reset release -> successive sample_out values 1000, 1875, 2640, ...; monotonic; reaches exactly 8000 and holds. Each value is stable for 64 clocks, updating on edges 66, 130, 194.
- Negative full-scale step, sample_in=-32768 -> output decays monotonically to exactly -32768 with no wrap. Then step to +32767 -> output converges to 32767 with no overflow or wrap.
- Bypass build (ALPHA_SHIFT=0), feed 1 kHz sine samples at one per 64 clocks -> sample_out equals each input sample 2 edges after capture, bit-exact.
- Pulse rejection, steady 0 then a single-sample impulse of 16000 -> output peaks at 2000 (16000/8), then decays geometrically: 1750, 1531, ... to 0.
- Mid-operation reset: assert rst_n=0 for 1 clock during a steady 8000 input -> sample_out=0 next edge, acc cleared. Step response restarts from 1000 on edge 66 after release.
